// File: rtl/regfile_mp_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_scoreboard_if
// Bundles every non-clock, non-reset signal of the multi-port register file
// and busy scoreboard.
//   master : decode/writeback side (drives addresses, writes, reserve, flush)
//   slave  : the register file itself
// Signals:
//   rd_addr  [NUM_READ*ADDR_WIDTH]   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  [NUM_READ*DATA_WIDTH]   combinational read data, same slicing
//   rd_busy  [NUM_READ]              per-read-port hazard flag
//   wr_en    [NUM_WRITE]             per-write-port enable
//   wr_addr  [NUM_WRITE*ADDR_WIDTH]  write addresses
//   wr_data  [NUM_WRITE*DATA_WIDTH]  write data
//   rsv_en / rsv_addr                mark a destination register busy at issue
//   flush                            clear every busy bit
//   busy_vec [NUM_REGS]              registered busy bits
// ---------------------------------------------------------------------------
interface regfile_mp_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]             rd_busy;
  logic [NUM_WRITE-1:0]            wr_en;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
  logic                            rsv_en;
  logic [ADDR_WIDTH-1:0]           rsv_addr;
  logic                            flush;
  logic [NUM_REGS-1:0]             busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_mp_scoreboard
// Parametrised multi-port register file with a per-register busy scoreboard
// for the five-stage core. Decode reads operands and reserves destinations;
// writeback writes results and releases the matching busy bits.
// Ports:
//   clock : rising-edge clock for all state
//   reset : asynchronous active-low reset (clears registers and busy bits)
//   bus   : regfile_mp_scoreboard_if.slave (read/write ports, reserve,
//           flush, hazard flags and registered busy vector)
// Parameters:
//   DATA_WIDTH, NUM_REGS (power of two), ADDR_WIDTH (derived), NUM_READ,
//   NUM_WRITE, ZERO_REG (x0 hardwired to zero), BYPASS (write-to-read
//   forwarding in the write cycle).
// ---------------------------------------------------------------------------
module regfile_mp_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                    clock,
  input logic                    reset,
  regfile_mp_scoreboard_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [ADDR_WIDTH-1:0] wr_addr_s [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wr_data_s [NUM_WRITE];
  logic [NUM_WRITE-1:0]  wr_store_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_data_s [NUM_READ];
  logic [NUM_READ-1:0]   rd_busy_s;
  logic                  hit_s;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   busy_next_s;

  // Unpack the flat bus slices into per-port arrays.
  for (genvar gj = 0; gj < NUM_WRITE; gj++) begin : g_wr_unpack
    assign wr_addr_s[gj] = bus.wr_addr[gj*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_s[gj] = bus.wr_data[gj*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd_pack
    assign rd_addr_s[gi]                              = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data_s[gi];
  end

  assign bus.rd_busy  = rd_busy_s;
  assign bus.busy_vec = busy_r;

  // Qualify write enables: with a hardwired zero register, writes to x0 never store.
  always_comb begin
    wr_store_s = {NUM_WRITE{1'b0}};
    for (int j = 0; j < NUM_WRITE; j++) begin
      if ((ZERO_REG != 0) && (wr_addr_s[j] == ADDR_ZERO)) begin
        wr_store_s[j] = 1'b0;
      end else begin
        wr_store_s[j] = bus.wr_en[j];
      end
    end
  end

  // Register array: ports are applied in index order so the highest enabled port wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_store_s[j]) begin
          regs_r[wr_addr_s[j]] <= wr_data_s[j];
        end
      end
    end
  end

  // Scoreboard next state: flush beats reserve, reserve beats release.
  // Release is applied before reserve so a same-address reserve leaves the bit set.
  always_comb begin
    busy_next_s = busy_r;
    if (bus.flush) begin
      busy_next_s = {NUM_REGS{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        busy_next_s[wr_addr_s[j]] = bus.wr_en[j] ? 1'b0 : busy_next_s[wr_addr_s[j]];
      end
      busy_next_s[bus.rsv_addr] = bus.rsv_en ? 1'b1 : busy_next_s[bus.rsv_addr];
    end
    // x0 can never become busy when it is hardwired to zero.
    busy_next_s[0] = (ZERO_REG != 0) ? 1'b0 : busy_next_s[0];
  end

  // Busy bit register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  // A forwarded write also clears the hazard, since the operand is available now.
  // Reads are forced to zero while reset is held so a pending write cannot leak through.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data_s[i] = {DATA_WIDTH{1'b0}};
      rd_busy_s[i] = 1'b0;
      if (!reset) begin
        rd_data_s[i] = {DATA_WIDTH{1'b0}};
        rd_busy_s[i] = 1'b0;
      end else if ((ZERO_REG != 0) && (rd_addr_s[i] == ADDR_ZERO)) begin
        rd_data_s[i] = {DATA_WIDTH{1'b0}};
        rd_busy_s[i] = 1'b0;
      end else begin
        rd_data_s[i] = regs_r[rd_addr_s[i]];
        rd_busy_s[i] = busy_r[rd_addr_s[i]];
        for (int j = 0; j < NUM_WRITE; j++) begin
          hit_s        = (BYPASS != 0) && bus.wr_en[j] && (wr_addr_s[j] == rd_addr_s[i]);
          rd_data_s[i] = hit_s ? wr_data_s[j] : rd_data_s[i];
          rd_busy_s[i] = rd_busy_s[i] & ~hit_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_scoreboard
// Four configurations of the register file driven from one stimulus stream:
//   cfg0: 32b x 32 regs, 2R/2W, zero reg, bypass
//   cfg1: 32b x 32 regs, 2R/2W, no zero reg, no bypass
//   cfg2: 64b x 16 regs, 4R/1W, zero reg, bypass
//   cfg3: 64b x 16 regs, 1R/2W, no zero reg, bypass
// A behavioural model (plain arrays) predicts every output each cycle; a
// directed table additionally pins hand-derived values on cfg0.
// ---------------------------------------------------------------------------
module tb_regfile_mp_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_mp_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2)) bus0 ();
  regfile_mp_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2)) bus1 ();
  regfile_mp_scoreboard_if #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_READ(4), .NUM_WRITE(1)) bus2 ();
  regfile_mp_scoreboard_if #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_READ(1), .NUM_WRITE(2)) bus3 ();

  regfile_mp_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2),
                          .ZERO_REG(1), .BYPASS(1)) u_cfg0 (.clock(clock), .reset(reset), .bus(bus0));
  regfile_mp_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2),
                          .ZERO_REG(0), .BYPASS(0)) u_cfg1 (.clock(clock), .reset(reset), .bus(bus1));
  regfile_mp_scoreboard #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_READ(4), .NUM_WRITE(1),
                          .ZERO_REG(1), .BYPASS(1)) u_cfg2 (.clock(clock), .reset(reset), .bus(bus2));
  regfile_mp_scoreboard #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_READ(1), .NUM_WRITE(2),
                          .ZERO_REG(0), .BYPASS(1)) u_cfg3 (.clock(clock), .reset(reset), .bus(bus3));

  int cfg_dw    [4] = '{32, 32, 64, 64};
  int cfg_nregs [4] = '{32, 32, 16, 16};
  int cfg_nrd   [4] = '{2, 2, 4, 1};
  int cfg_nwr   [4] = '{2, 2, 1, 2};
  int cfg_zr    [4] = '{1, 0, 1, 0};
  int cfg_bp    [4] = '{1, 0, 1, 1};

  int n_vec = 0;
  int n_err = 0;

  // Stimulus (widest form; each configuration takes the slice it has)
  logic [4:0]  s_ra [4];
  logic [1:0]  s_we;
  logic [4:0]  s_wa [2];
  logic [63:0] s_wd [2];
  logic        s_rsv;
  logic [4:0]  s_rsa;
  logic        s_fl;

  // Reference model state
  logic [63:0] m_mem  [4][32];
  logic        m_busy [4][32];
  logic        in_reset;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        rsv;
    logic [4:0]  rsa;
    logic        fl;
    logic [31:0] e_rd0, e_rd1;
    logic        e_b0, e_b1;
    logic [31:0] e_bv;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[c][k]  = 64'h0;
        m_busy[c][k] = 1'b0;
      end
    end
  endtask

  function automatic logic [63:0] exp_rd(int c, int i);
    int mask;
    int a;
    logic [63:0] v;
    mask = cfg_nregs[c] - 1;
    a    = int'(s_ra[i]) & mask;
    if (in_reset) return 64'h0;
    if (cfg_zr[c] != 0 && a == 0) return 64'h0;
    v = m_mem[c][a];
    if (cfg_bp[c] != 0) begin
      for (int j = 0; j < cfg_nwr[c]; j++) begin
        if (s_we[j] && ((int'(s_wa[j]) & mask) == a)) v = s_wd[j];
      end
    end
    if (cfg_dw[c] == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic exp_busy(int c, int i);
    int mask;
    int a;
    logic b;
    mask = cfg_nregs[c] - 1;
    a    = int'(s_ra[i]) & mask;
    if (in_reset) return 1'b0;
    b = m_busy[c][a];
    if (cfg_bp[c] != 0) begin
      for (int j = 0; j < cfg_nwr[c]; j++) begin
        if (s_we[j] && ((int'(s_wa[j]) & mask) == a)) b = 1'b0;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] exp_bv(int c);
    logic [31:0] bv;
    bv = 32'h0;
    for (int k = 0; k < cfg_nregs[c]; k++) bv[k] = m_busy[c][k];
    return bv;
  endfunction

  // Effect of one rising edge on the architectural state.
  task automatic model_clock();
    int mask;
    int a;
    for (int c = 0; c < 4; c++) begin
      mask = cfg_nregs[c] - 1;
      for (int j = 0; j < cfg_nwr[c]; j++) begin
        a = int'(s_wa[j]) & mask;
        if (s_we[j] && !(cfg_zr[c] != 0 && a == 0))
          m_mem[c][a] = (cfg_dw[c] == 32) ? (s_wd[j] & 64'h0000_0000_FFFF_FFFF) : s_wd[j];
      end
      if (s_fl) begin
        for (int k = 0; k < 32; k++) m_busy[c][k] = 1'b0;
      end else begin
        for (int j = 0; j < cfg_nwr[c]; j++) begin
          if (s_we[j]) m_busy[c][int'(s_wa[j]) & mask] = 1'b0;
        end
        a = int'(s_rsa) & mask;
        if (s_rsv && !(cfg_zr[c] != 0 && a == 0)) m_busy[c][a] = 1'b1;
      end
    end
  endtask

  task automatic drive();
    bus0.rd_addr  = {s_ra[1], s_ra[0]};
    bus0.wr_en    = s_we;
    bus0.wr_addr  = {s_wa[1], s_wa[0]};
    bus0.wr_data  = {s_wd[1][31:0], s_wd[0][31:0]};
    bus0.rsv_en   = s_rsv;
    bus0.rsv_addr = s_rsa;
    bus0.flush    = s_fl;
    bus1.rd_addr  = {s_ra[1], s_ra[0]};
    bus1.wr_en    = s_we;
    bus1.wr_addr  = {s_wa[1], s_wa[0]};
    bus1.wr_data  = {s_wd[1][31:0], s_wd[0][31:0]};
    bus1.rsv_en   = s_rsv;
    bus1.rsv_addr = s_rsa;
    bus1.flush    = s_fl;
    bus2.rd_addr  = {s_ra[3][3:0], s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};
    bus2.wr_en    = s_we[0];
    bus2.wr_addr  = s_wa[0][3:0];
    bus2.wr_data  = s_wd[0];
    bus2.rsv_en   = s_rsv;
    bus2.rsv_addr = s_rsa[3:0];
    bus2.flush    = s_fl;
    bus3.rd_addr  = s_ra[0][3:0];
    bus3.wr_en    = s_we;
    bus3.wr_addr  = {s_wa[1][3:0], s_wa[0][3:0]};
    bus3.wr_data  = {s_wd[1], s_wd[0]};
    bus3.rsv_en   = s_rsv;
    bus3.rsv_addr = s_rsa[3:0];
    bus3.flush    = s_fl;
  endtask

  task automatic check_all();
    logic [63:0] got;
    logic        gb;
    logic [31:0] gbv;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < cfg_nrd[c]; i++) begin
        case (c)
          0:       begin got = {32'h0, bus0.rd_data[i*32 +: 32]}; gb = bus0.rd_busy[i]; end
          1:       begin got = {32'h0, bus1.rd_data[i*32 +: 32]}; gb = bus1.rd_busy[i]; end
          2:       begin got = bus2.rd_data[i*64 +: 64];          gb = bus2.rd_busy[i]; end
          default: begin got = bus3.rd_data[63:0];                gb = bus3.rd_busy[0]; end
        endcase
        check($sformatf("cfg%0d rd_data[%0d]", c, i), got, exp_rd(c, i));
        check($sformatf("cfg%0d rd_busy[%0d]", c, i), {63'h0, gb}, {63'h0, exp_busy(c, i)});
      end
      case (c)
        0:       gbv = bus0.busy_vec;
        1:       gbv = bus1.busy_vec;
        2:       gbv = {16'h0, bus2.busy_vec};
        default: gbv = {16'h0, bus3.busy_vec};
      endcase
      check($sformatf("cfg%0d busy_vec", c), {32'h0, gbv}, {32'h0, exp_bv(c)});
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) s_ra[i] = 5'd0;
    s_we = 2'b00;
    for (int j = 0; j < 2; j++) begin
      s_wa[j] = 5'd0;
      s_wd[j] = 64'h0;
    end
    s_rsv = 1'b0;
    s_rsa = 5'd0;
    s_fl  = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_stim();
    for (int i = 0; i < 4; i++) s_ra[i] = pick();
    s_we = 2'($urandom_range(0, 3));
    for (int j = 0; j < 2; j++) begin
      s_wa[j] = pick();
      s_wd[j] = {$urandom(), $urandom()};
    end
    s_rsv = 1'($urandom_range(0, 1));
    s_rsa = pick();
    s_fl  = ($urandom_range(0, 15) == 0);
  endtask

  task automatic post_edge();
    @(posedge clock);
    if (!in_reset) model_clock();
    @(negedge clock);
  endtask

  task automatic step();
    drive();
    #1;
    check_all();
    post_edge();
  endtask

  initial begin
    //        we     wa0    wa1    wd0           wd1           ra0    ra1    rsv   rsa    fl    e_rd0         e_rd1         b0    b1    bv
    tbl[0]  = '{2'b11, 5'd7,  5'd0, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7,  5'd0, 1'b0, 5'd0,  1'b0, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[1]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd7,  5'd0, 1'b0, 5'd0,  1'b0, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 32'h0};
    tbl[2]  = '{2'b11, 5'd3,  5'd3, 32'hA,         32'hB,         5'd3,  5'd3, 1'b0, 5'd0,  1'b0, 32'hB,         32'hB,         1'b0, 1'b0, 32'h0};
    tbl[3]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd3,  5'd7, 1'b0, 5'd0,  1'b0, 32'hB,         32'h1234_5678, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd10, 5'd3, 1'b1, 5'd10, 1'b0, 32'h0,         32'hB,         1'b0, 1'b0, 32'h0};
    tbl[5]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd10, 5'd10,1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h400};
    tbl[6]  = '{2'b01, 5'd10, 5'd0, 32'h55,        32'h0,         5'd10, 5'd3, 1'b0, 5'd0,  1'b0, 32'h55,        32'hB,         1'b0, 1'b0, 32'h400};
    tbl[7]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd10, 5'd10,1'b0, 5'd0,  1'b0, 32'h55,        32'h55,        1'b0, 1'b0, 32'h0};
    tbl[8]  = '{2'b10, 5'd0,  5'd4, 32'h0,         32'h44,        5'd4,  5'd4, 1'b1, 5'd4,  1'b0, 32'h44,        32'h44,        1'b0, 1'b0, 32'h0};
    tbl[9]  = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd4,  5'd4, 1'b0, 5'd0,  1'b0, 32'h44,        32'h44,        1'b1, 1'b1, 32'h10};
    tbl[10] = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd4,  5'd9, 1'b1, 5'd9,  1'b1, 32'h44,        32'h0,         1'b1, 1'b0, 32'h10};
    tbl[11] = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd4,  5'd9, 1'b0, 5'd0,  1'b0, 32'h44,        32'h0,         1'b0, 1'b0, 32'h0};
    tbl[12] = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd0,  5'd0, 1'b1, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
    tbl[13] = '{2'b00, 5'd0,  5'd0, 32'h0,         32'h0,         5'd0,  5'd4, 1'b0, 5'd0,  1'b0, 32'h0,         32'h44,        1'b0, 1'b0, 32'h0};

    // Reset held for three edges while writes to x5 are presented.
    reset    = 1'b0;
    in_reset = 1'b1;
    model_reset();
    idle();
    drive();
    @(negedge clock);
    for (int n = 0; n < 3; n++) begin
      idle();
      s_we    = 2'b11;
      s_wa[0] = 5'd5;
      s_wa[1] = 5'd5;
      s_wd[0] = 64'hDEAD_BEEF;
      s_wd[1] = 64'hDEAD_BEEF;
      s_ra[0] = 5'd5;
      s_ra[1] = 5'd5;
      step();
    end
    reset    = 1'b1;
    in_reset = 1'b0;
    idle();
    s_ra[0] = 5'd5;
    s_ra[1] = 5'd5;
    step();

    // Directed table; cfg0 outputs also pinned against hand-derived values.
    for (int v = 0; v < 14; v++) begin
      s_we    = tbl[v].we;
      s_wa[0] = tbl[v].wa0;
      s_wa[1] = tbl[v].wa1;
      s_wd[0] = {32'h0, tbl[v].wd0};
      s_wd[1] = {32'h0, tbl[v].wd1};
      s_ra[0] = tbl[v].ra0;
      s_ra[1] = tbl[v].ra1;
      s_ra[2] = 5'd0;
      s_ra[3] = 5'd0;
      s_rsv   = tbl[v].rsv;
      s_rsa   = tbl[v].rsa;
      s_fl    = tbl[v].fl;
      drive();
      #1;
      check_all();
      check($sformatf("tbl%0d rd0", v), {32'h0, bus0.rd_data[31:0]},  {32'h0, tbl[v].e_rd0});
      check($sformatf("tbl%0d rd1", v), {32'h0, bus0.rd_data[63:32]}, {32'h0, tbl[v].e_rd1});
      check($sformatf("tbl%0d busy0", v), {63'h0, bus0.rd_busy[0]}, {63'h0, tbl[v].e_b0});
      check($sformatf("tbl%0d busy1", v), {63'h0, bus0.rd_busy[1]}, {63'h0, tbl[v].e_b1});
      check($sformatf("tbl%0d busy_vec", v), {32'h0, bus0.busy_vec}, {32'h0, tbl[v].e_bv});
      post_edge();
    end

    // Random burst, then reset asserted between edges with a write pending.
    for (int n = 0; n < 40; n++) begin
      rand_stim();
      step();
    end
    rand_stim();
    s_we  = 2'b11;
    s_rsv = 1'b1;
    s_fl  = 1'b0;
    drive();
    #2;
    reset    = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    @(negedge clock);
    drive();
    #1;
    check_all();
    reset    = 1'b1;
    in_reset = 1'b0;

    // Long randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      rand_stim();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
